id_issue_stage: RTL and testbench
=================================

Name: id_issue_stage

Overview:
- Decode/issue stage that sits directly upstream of the ID/EX boundary.
- Drives the register-file read addresses from the IF/ID instruction and samples the two read ports.
- Generates the immediate and captures a decoded operand bundle into the ID/EX pipeline register.
- A 31-entry busy-bit scoreboard interlocks RAW/WAW hazards against in-flight writes; the writeback port clears entries.

Parameters:
CNT_W, 16, width of the saturating hazard-stall counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
if_valid  in  1  IF/ID holds an instruction
if_instr  in  32  instruction word
if_pc  in  32  instruction PC
id_ready  out  1  combinational: ex_ready && !hazard
flush  in  1  discard the instruction at the ID input this cycle
rf_rd_addr0  out  5  combinational: if_instr[19:15]
rf_rd_addr1  out  5  combinational: if_instr[24:20]
rf_rd_data0  in  32  register-file port 0 data
rf_rd_data1  in  32  register-file port 1 data
wb_wr_ena  in  1  writeback commit (same signal driving the register-file write enable)
wb_wr_addr  in  5  writeback destination
ex_ready  in  1  EX accepts the ID/EX contents this cycle
ex_valid  out  1  ID/EX holds a live instruction
ex_pc  out  32  captured PC
ex_rs1_data  out  32  captured operand 0
ex_rs2_data  out  32  captured operand 1
ex_imm  out  32  sign-extended immediate
ex_rd  out  5  destination; 0 if the instruction has no write
ex_opcode  out  7  instr[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7_5  out  1  instr[30]
ex_illegal  out  1  opcode not recognised
stall_cycles  out  CNT_W  saturating count of hazard stalls

Behaviour:
Reset:
- All ex_* outputs are 0; all busy bits are 0; stall_cycles is 0. rst overrides every other input.

Decode by opcode:
- Writes rd: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, LOAD 0000011, OP-IMM 0010011, OP 0110011.
- Uses rs1: JALR, BRANCH 1100011, LOAD, STORE 0100011, OP-IMM, OP.
- Uses rs2: BRANCH, STORE, OP.
- Any other opcode: ex_illegal=1, no rs use, no rd write, ex_imm=0.

Immediates:
- I: instr[31:20] sign-extended.
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- All immediates are sign-extended from bit 31.

Hazard and scoreboard:
- hazard = if_valid && ((uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (writes_rd && busy[rd])).
- busy[0] is constant 0.
- The hazard decision uses registered busy bits only. A wb clear in cycle N releases the stall in cycle N+1; the register file commits on the negedge of N, so data read in N+1 is current.

Advance rules (priority order):
- rst.
- ex_ready=0: all ID/EX outputs hold; no capture; no busy set.
- flush=1: ex_valid<=0; instruction discarded; no busy set.
- hazard: ex_valid<=0 (bubble); stall_cycles increments, saturating at all-ones.
- if_valid: capture the bundle; ex_valid<=1; if writes_rd and rd!=0, set busy[rd].
- Otherwise: ex_valid<=0.

Latency and scoreboard timing:
- Capture-to-output latency is 1 cycle; operands are sampled from rf_rd_data* at the capturing edge.
- A wb clear applies every cycle regardless of stall or flush: busy[wb_wr_addr]<=0 when wb_wr_ena && wb_wr_addr!=0.
- Set and clear never target the same index in one cycle; the WAW check guarantees this.
- Backpressure (ex_ready=0) does not count as a stall. Flush does not touch busy bits.

Test Plan:
- Reset, then issue `addi x5,x0,7` (0x00700293) at pc 0x100 with rf data 0 -> next cycle ex_valid=1, ex_rd=5, ex_imm=7, ex_pc=0x100; busy[5]=1.
- Next cycle issue `add x6,x5,x5` -> id_ready=0 and ex_valid=0 bubbles; stall_cycles increments each cycle. Pulse wb_wr_ena with wb_wr_addr=5 at cycle N -> issue at N+1 with ex_rs1_data=ex_rs2_data=7 from the rf.
- Stream `addi x0,x0,1` then `add x1,x0,x0` -> no busy set for x0; no stall; ex_rd=0 for the first.
- Issue 0xFE000EE3 (`beq x0,x0,-4`) -> ex_imm=0xFFFFFFFC, ex_rd=0; then opcode 0x7F -> ex_illegal=1.
- Hold ex_ready=0 for 3 cycles with a valid instruction pending -> outputs are stable, id_ready=0, stall_cycles is unchanged; release -> capture on the next edge.
- flush with a valid `addi x7,...` -> ex_valid=0 and busy[7] stays 0.
- With CNT_W=4, hold a hazard for 20 cycles -> stall_cycles saturates at 15.
- Assert rst mid-stall -> all busy bits clear and outputs are 0 on the next edge.

Source files
------------

// File: rtl/id_issue_stage_if.sv
// ID/EX boundary bundle.
// The issue stage drives the captured instruction bundle (master side) and
// the execute stage drives ex_ready back (slave side).
//   ex_valid     : ID/EX holds a live instruction
//   ex_ready     : EX accepts the ID/EX contents this cycle
//   ex_pc        : captured PC
//   ex_rs1_data  : captured operand 0
//   ex_rs2_data  : captured operand 1
//   ex_imm       : sign-extended immediate
//   ex_rd        : destination register, 0 when the instruction has no write
//   ex_opcode    : instr[6:0]
//   ex_funct3    : instr[14:12]
//   ex_funct7_5  : instr[30]
//   ex_illegal   : opcode not recognised
interface id_issue_stage_if;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7_5;
    logic        ex_illegal;

    modport master (
        output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
               ex_opcode, ex_funct3, ex_funct7_5, ex_illegal,
        input  ex_ready
    );

    modport slave (
        input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd,
               ex_opcode, ex_funct3, ex_funct7_5, ex_illegal,
        output ex_ready
    );
endinterface

// File: rtl/id_issue_stage.sv
// Decode/issue stage feeding the ID/EX pipeline register.
// Decodes the IF/ID instruction, drives the register-file read addresses,
// builds the immediate and captures the operand bundle into ID/EX. A busy-bit
// scoreboard over x1..x31 interlocks RAW/WAW hazards against in-flight writes;
// the writeback port clears entries.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   if_valid/if_instr/if_pc : instruction at the ID input
//   id_ready              : ex_ready && !hazard (combinational)
//   flush                 : discard the instruction at the ID input
//   rf_rd_addr0/1         : register-file read addresses (rs1, rs2)
//   rf_rd_data0/1         : register-file read data
//   wb_wr_ena/wb_wr_addr  : writeback commit, clears the busy bit
//   ex                    : ID/EX bundle (master side)
//   stall_cycles          : saturating count of hazard stalls
module id_issue_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [31:0]      if_instr,
    input  logic [31:0]      if_pc,
    output logic             id_ready,
    input  logic             flush,
    output logic [4:0]       rf_rd_addr0,
    output logic [4:0]       rf_rd_addr1,
    input  logic [31:0]      rf_rd_data0,
    input  logic [31:0]      rf_rd_data1,
    input  logic             wb_wr_ena,
    input  logic [4:0]       wb_wr_addr,
    id_issue_stage_if.master ex,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [6:0]  opcode;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        uses_rs1, uses_rs2, writes_rd, illegal;
    logic [31:0] imm_next;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode      = if_instr[6:0];
    assign rs1_addr    = if_instr[19:15];
    assign rs2_addr    = if_instr[24:20];
    assign rd_addr     = if_instr[11:7];
    assign rf_rd_addr0 = rs1_addr;
    assign rf_rd_addr1 = rs2_addr;

    assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
    assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7],
                    if_instr[30:25], if_instr[11:8], 1'b0};
    assign imm_u = {if_instr[31:12], 12'b0};
    assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12],
                    if_instr[20], if_instr[30:21], 1'b0};

    // Register-register ops carry no immediate, so ex_imm is 0 for OP.
    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        illegal   = 1'b0;
        imm_next  = 32'd0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                writes_rd = 1'b1;
                imm_next  = imm_u;
            end
            OPC_JAL: begin
                writes_rd = 1'b1;
                imm_next  = imm_j;
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                imm_next  = imm_i;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_next = imm_b;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm_next = imm_s;
            end
            OPC_OP: begin
                writes_rd = 1'b1;
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    // Scoreboard: x0 is never busy, so it is hard-wired into bit 0 of the view.
    logic [31:1] busy_reg, busy_next;
    logic [31:0] busy_vec;
    logic        hazard, capture, busy_set, busy_clr;

    assign busy_vec = {busy_reg, 1'b0};

    // Only registered busy bits are consulted; a writeback clear releases the
    // stall one cycle later, when the register file already holds the data.
    assign hazard = if_valid && ((uses_rs1  && busy_vec[rs1_addr]) ||
                                 (uses_rs2  && busy_vec[rs2_addr]) ||
                                 (writes_rd && busy_vec[rd_addr]));

    assign id_ready = ex.ex_ready && !hazard;
    assign capture  = ex.ex_ready && !flush && !hazard && if_valid;
    assign busy_set = capture && writes_rd;
    assign busy_clr = wb_wr_ena;

    // The WAW check keeps set and clear off the same index in one cycle.
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_busy
            assign busy_next[gi] = (busy_set && rd_addr == 5'(gi))    ? 1'b1 :
                                   (busy_clr && wb_wr_addr == 5'(gi)) ? 1'b0 :
                                   busy_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Hazard stall counter; backpressure and flush cycles are not stalls.
    logic [CNT_W-1:0] stall_cycles_reg, stall_cycles_next;

    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (ex.ex_ready && !flush && hazard && stall_cycles_reg != {CNT_W{1'b1}}) begin
            stall_cycles_next = stall_cycles_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_reg <= '0;
        end else begin
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    assign stall_cycles = stall_cycles_reg;

    // ID/EX register; payload holds when nothing is captured.
    logic        ex_valid_reg, ex_funct7_5_reg, ex_illegal_reg;
    logic [31:0] ex_pc_reg, ex_rs1_data_reg, ex_rs2_data_reg, ex_imm_reg;
    logic [4:0]  ex_rd_reg;
    logic [6:0]  ex_opcode_reg;
    logic [2:0]  ex_funct3_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_reg    <= 1'b0;
            ex_pc_reg       <= '0;
            ex_rs1_data_reg <= '0;
            ex_rs2_data_reg <= '0;
            ex_imm_reg      <= '0;
            ex_rd_reg       <= '0;
            ex_opcode_reg   <= '0;
            ex_funct3_reg   <= '0;
            ex_funct7_5_reg <= 1'b0;
            ex_illegal_reg  <= 1'b0;
        end else if (ex.ex_ready) begin
            ex_valid_reg <= capture;
            if (capture) begin
                ex_pc_reg       <= if_pc;
                ex_rs1_data_reg <= rf_rd_data0;
                ex_rs2_data_reg <= rf_rd_data1;
                ex_imm_reg      <= imm_next;
                ex_rd_reg       <= writes_rd ? rd_addr : 5'd0;
                ex_opcode_reg   <= opcode;
                ex_funct3_reg   <= if_instr[14:12];
                ex_funct7_5_reg <= if_instr[30];
                ex_illegal_reg  <= illegal;
            end
        end
    end

    assign ex.ex_valid    = ex_valid_reg;
    assign ex.ex_pc       = ex_pc_reg;
    assign ex.ex_rs1_data = ex_rs1_data_reg;
    assign ex.ex_rs2_data = ex_rs2_data_reg;
    assign ex.ex_imm      = ex_imm_reg;
    assign ex.ex_rd       = ex_rd_reg;
    assign ex.ex_opcode   = ex_opcode_reg;
    assign ex.ex_funct3   = ex_funct3_reg;
    assign ex.ex_funct7_5 = ex_funct7_5_reg;
    assign ex.ex_illegal  = ex_illegal_reg;
endmodule

// File: tb/tb_id_issue_stage.sv
// Self-checking bench for id_issue_stage: directed scenarios followed by a
// randomized stream, checked against a behavioural decode/scoreboard model.
module tb_id_issue_stage;
    localparam int CNT_W = 4;
    localparam int STALL_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, if_valid, flush, wb_wr_ena;
    logic [31:0]      if_instr, if_pc;
    logic [4:0]       wb_wr_addr;
    wire              id_ready;
    wire  [4:0]       rf_rd_addr0, rf_rd_addr1;
    wire  [31:0]      rf_rd_data0, rf_rd_data1;
    wire  [CNT_W-1:0] stall_cycles;

    id_issue_stage_if ex_bus ();

    always #5 clk = ~clk;

    // Register-file contents as seen by the stage.
    logic [31:0] rf [32];
    assign rf_rd_data0 = rf[if_instr[19:15]];
    assign rf_rd_data1 = rf[if_instr[24:20]];

    id_issue_stage #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .id_ready     (id_ready),
        .flush        (flush),
        .rf_rd_addr0  (rf_rd_addr0),
        .rf_rd_addr1  (rf_rd_addr1),
        .rf_rd_data0  (rf_rd_data0),
        .rf_rd_data1  (rf_rd_data1),
        .wb_wr_ena    (wb_wr_ena),
        .wb_wr_addr   (wb_wr_addr),
        .ex           (ex_bus.master),
        .stall_cycles (stall_cycles)
    );

    typedef struct packed {
        bit        valid;
        bit [31:0] pc;
        bit [31:0] rs1;
        bit [31:0] rs2;
        bit [31:0] imm;
        bit [4:0]  rd;
        bit [6:0]  opc;
        bit [2:0]  f3;
        bit        f75;
        bit        ill;
    } ex_t;

    ex_t       m_ex;
    bit        m_busy [32];
    int        m_stall;
    bit        m_init;
    bit        m_consumed;
    bit [31:0] wb_data;
    int        total = 0;
    int        bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the instruction-set rules.
    function automatic void decode(input bit [31:0] ins, output bit u1, output bit u2,
                                   output bit wr, output bit ill, output bit [31:0] imm);
        bit [31:0] sx;
        sx  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
        u1  = 0; u2 = 0; wr = 0; ill = 0; imm = 0;
        case (ins[6:0])
            7'h37, 7'h17: begin wr = 1; imm = ins & 32'hFFFF_F000; end
            7'h6F: begin
                wr  = 1;
                imm = (sx << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11)
                    | (32'(ins[30:21]) << 1);
            end
            7'h67, 7'h03, 7'h13: begin wr = 1; u1 = 1; imm = (sx << 12) | 32'(ins[31:20]); end
            7'h63: begin
                u1  = 1; u2 = 1;
                imm = (sx << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5)
                    | (32'(ins[11:8]) << 1);
            end
            7'h23: begin
                u1  = 1; u2 = 1;
                imm = (sx << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
            end
            7'h33: begin wr = 1; u1 = 1; u2 = 1; end
            default: ill = 1;
        endcase
    endfunction

    // One clock: check combinational outputs, advance the model, check ID/EX.
    task automatic cycle();
        bit u1, u2, wr, ill, hz, set_b;
        bit [31:0] imm;
        bit [4:0] rs1, rs2, rd;
        #1;
        rs1 = if_instr[19:15];
        rs2 = if_instr[24:20];
        rd  = if_instr[11:7];
        decode(if_instr, u1, u2, wr, ill, imm);
        hz = if_valid && ((u1 && m_busy[rs1]) || (u2 && m_busy[rs2]) || (wr && m_busy[rd]));
        if (m_init) begin
            chk("id_ready", 32'(id_ready), 32'(ex_bus.ex_ready && !hz));
            chk("rf_rd_addr0", 32'(rf_rd_addr0), 32'(rs1));
            chk("rf_rd_addr1", 32'(rf_rd_addr1), 32'(rs2));
        end
        @(posedge clk);
        #1;
        set_b = 0;
        if (rst) begin
            m_ex = '0;
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
            m_stall = 0;
            m_consumed = 1;
            m_init = 1;
        end else begin
            m_consumed = !if_valid || (ex_bus.ex_ready && (flush || !hz));
            if (ex_bus.ex_ready) begin
                if (flush) m_ex.valid = 0;
                else if (hz) begin
                    m_ex.valid = 0;
                    if (m_stall < STALL_MAX) m_stall++;
                end else if (if_valid) begin
                    m_ex.valid = 1;
                    m_ex.pc    = if_pc;
                    m_ex.rs1   = rf[rs1];
                    m_ex.rs2   = rf[rs2];
                    m_ex.imm   = imm;
                    m_ex.rd    = wr ? rd : 5'd0;
                    m_ex.opc   = if_instr[6:0];
                    m_ex.f3    = if_instr[14:12];
                    m_ex.f75   = if_instr[30];
                    m_ex.ill   = ill;
                    set_b      = wr && rd != 0;
                end else m_ex.valid = 0;
            end
            if (wb_wr_ena && wb_wr_addr != 0) begin
                m_busy[wb_wr_addr] = 0;
                rf[wb_wr_addr] = wb_data;
            end
            if (set_b) m_busy[rd] = 1;
        end
        if (m_init) begin
            chk("ex_valid", 32'(ex_bus.ex_valid), 32'(m_ex.valid));
            chk("stall_cycles", 32'(stall_cycles), 32'(m_stall));
            if (m_ex.valid || rst) begin
                chk("ex_pc", ex_bus.ex_pc, m_ex.pc);
                chk("ex_rs1_data", ex_bus.ex_rs1_data, m_ex.rs1);
                chk("ex_rs2_data", ex_bus.ex_rs2_data, m_ex.rs2);
                chk("ex_imm", ex_bus.ex_imm, m_ex.imm);
                chk("ex_rd", 32'(ex_bus.ex_rd), 32'(m_ex.rd));
                chk("ex_opcode", 32'(ex_bus.ex_opcode), 32'(m_ex.opc));
                chk("ex_funct3", 32'(ex_bus.ex_funct3), 32'(m_ex.f3));
                chk("ex_funct7_5", 32'(ex_bus.ex_funct7_5), 32'(m_ex.f75));
                chk("ex_illegal", 32'(ex_bus.ex_illegal), 32'(m_ex.ill));
            end
        end
        $display("cyc rst=%0d v=%0d ins=%h rdy=%0d fl=%0d wb=%0d/%0d -> ex_v=%0d pc=%h rd=%0d stall=%0d",
                 rst, if_valid, if_instr, ex_bus.ex_ready, flush, wb_wr_ena, wb_wr_addr,
                 ex_bus.ex_valid, ex_bus.ex_pc, ex_bus.ex_rd, stall_cycles);
    endtask

    initial begin
        bit [6:0] opcs [10];
        int cand [$];
        int saved;
        opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h33, 7'h63, 7'h23, 7'h7F};
        for (int i = 0; i < 32; i++) begin rf[i] = 0; m_busy[i] = 0; end
        rst = 1; if_valid = 0; if_instr = 0; if_pc = 0; flush = 0;
        wb_wr_ena = 0; wb_wr_addr = 0; wb_data = 0; ex_bus.ex_ready = 1;
        m_init = 0; m_ex = '0; m_stall = 0; m_consumed = 1;

        // Reset
        cycle(); cycle();
        chk("reset_valid", 32'(ex_bus.ex_valid), 32'd0);
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        rst = 0;

        // addi x5,x0,7
        if_valid = 1; if_instr = 32'h0070_0293; if_pc = 32'h100;
        cycle();
        chk("addi_valid", 32'(ex_bus.ex_valid), 32'd1);
        chk("addi_rd", 32'(ex_bus.ex_rd), 32'd5);
        chk("addi_imm", ex_bus.ex_imm, 32'd7);
        chk("addi_pc", ex_bus.ex_pc, 32'h100);

        // add x6,x5,x5 stalls until x5 is written back
        if_instr = 32'h0052_8333; if_pc = 32'h104;
        repeat (3) cycle();
        chk("raw_stall_cnt", 32'(stall_cycles), 32'd3);
        chk("raw_bubble", 32'(ex_bus.ex_valid), 32'd0);
        wb_wr_ena = 1; wb_wr_addr = 5; wb_data = 7;
        cycle();
        wb_wr_ena = 0;
        chk("raw_stall_wb", 32'(stall_cycles), 32'd4);
        cycle();
        chk("raw_issue_valid", 32'(ex_bus.ex_valid), 32'd1);
        chk("raw_rs1", ex_bus.ex_rs1_data, 32'd7);
        chk("raw_rs2", ex_bus.ex_rs2_data, 32'd7);
        chk("raw_rd", 32'(ex_bus.ex_rd), 32'd6);

        // x0 destination and sources never interlock
        if_instr = 32'h0010_0013; if_pc = 32'h108;
        wb_wr_ena = 1; wb_wr_addr = 6; wb_data = 32'h1234;
        cycle();
        wb_wr_ena = 0;
        chk("x0_rd", 32'(ex_bus.ex_rd), 32'd0);
        if_instr = 32'h0000_00B3; if_pc = 32'h10C;
        cycle();
        chk("x0_no_stall", 32'(stall_cycles), 32'd4);
        chk("x0_valid", 32'(ex_bus.ex_valid), 32'd1);

        // Branch immediate, then illegal opcode
        if_instr = 32'hFE00_0EE3; if_pc = 32'h110;
        cycle();
        chk("beq_imm", ex_bus.ex_imm, 32'hFFFF_FFFC);
        chk("beq_rd", 32'(ex_bus.ex_rd), 32'd0);
        if_instr = 32'h0000_007F; if_pc = 32'h114;
        cycle();
        chk("illegal_flag", 32'(ex_bus.ex_illegal), 32'd1);
        chk("illegal_imm", ex_bus.ex_imm, 32'd0);

        // Backpressure holds everything and is not a stall
        ex_bus.ex_ready = 0; if_instr = 32'h0030_0413; if_pc = 32'h118;
        repeat (3) cycle();
        chk("bp_hold_pc", ex_bus.ex_pc, 32'h114);
        chk("bp_hold_valid", 32'(ex_bus.ex_valid), 32'd1);
        chk("bp_stall", 32'(stall_cycles), 32'd4);
        ex_bus.ex_ready = 1;
        cycle();
        chk("bp_release_pc", ex_bus.ex_pc, 32'h118);

        // Flush discards addi x7 without marking x7 busy
        flush = 1; if_instr = 32'h0010_0393; if_pc = 32'h11C;
        cycle();
        flush = 0;
        chk("flush_valid", 32'(ex_bus.ex_valid), 32'd0);
        cycle();
        chk("flush_no_busy", 32'(ex_bus.ex_valid), 32'd1);
        chk("flush_no_stall", 32'(stall_cycles), 32'd4);

        // Saturation: add x10,x7,x0 against busy x7 for 20 cycles
        if_instr = 32'h0003_8533; if_pc = 32'h120;
        repeat (20) cycle();
        chk("stall_saturate", 32'(stall_cycles), 32'd15);

        // Reset mid-stall clears the scoreboard
        rst = 1;
        cycle();
        chk("midrst_valid", 32'(ex_bus.ex_valid), 32'd0);
        chk("midrst_stall", 32'(stall_cycles), 32'd0);
        rst = 0;
        cycle();
        chk("midrst_issue", 32'(ex_bus.ex_valid), 32'd1);
        chk("midrst_pc", ex_bus.ex_pc, 32'h120);

        // Randomized stream
        saved = 0;
        for (int n = 0; n < 600; n++) begin
            if (m_consumed) begin
                if_instr = $urandom;
                if ($urandom_range(0, 19) != 0) if_instr[6:0] = opcs[$urandom_range(0, 9)];
                if_instr[19:15] = 5'($urandom_range(0, 7));
                if_instr[24:20] = 5'($urandom_range(0, 7));
                if_instr[11:7]  = 5'($urandom_range(0, 7));
                if_pc = $urandom & 32'hFFFF_FFFC;
                saved++;
            end
            if_valid        = ($urandom_range(0, 9) != 0);
            ex_bus.ex_ready = ($urandom_range(0, 5) != 0);
            flush           = ($urandom_range(0, 15) == 0);
            rst             = ($urandom_range(0, 199) == 0);
            cand.delete();
            for (int i = 1; i < 32; i++) if (m_busy[i]) cand.push_back(i);
            wb_wr_ena = 0;
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                wb_wr_ena  = 1;
                wb_wr_addr = 5'(cand[$urandom_range(0, cand.size() - 1)]);
                wb_data    = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                wb_wr_ena  = 1;
                wb_wr_addr = 0;
                wb_data    = $urandom;
            end
            cycle();
        end
        chk("random_progress", 32'(saved > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
